// File: rtl/axi_lite_reg_file_if.sv
// AXI4-Lite bus bundle (32-bit data) with master and slave views.
interface axi_lite_reg_file_if #(
    parameter int unsigned AXI_ADDR_WIDTH = 32
);
    logic [AXI_ADDR_WIDTH-1:0] aw_addr;
    logic                      aw_valid;
    logic                      aw_ready;
    logic [31:0]               w_data;
    logic [3:0]                w_strb;
    logic                      w_valid;
    logic                      w_ready;
    logic [1:0]                b_resp;
    logic                      b_valid;
    logic                      b_ready;
    logic [AXI_ADDR_WIDTH-1:0] ar_addr;
    logic                      ar_valid;
    logic                      ar_ready;
    logic [31:0]               r_data;
    logic [1:0]                r_resp;
    logic                      r_valid;
    logic                      r_ready;

    modport master (
        output aw_addr, aw_valid, w_data, w_strb, w_valid, b_ready, ar_addr, ar_valid, r_ready,
        input  aw_ready, w_ready, b_resp, b_valid, ar_ready, r_data, r_resp, r_valid
    );

    modport slave (
        input  aw_addr, aw_valid, w_data, w_strb, w_valid, b_ready, ar_addr, ar_valid, r_ready,
        output aw_ready, w_ready, b_resp, b_valid, ar_ready, r_data, r_resp, r_valid
    );
endinterface

// File: rtl/axi_lite_reg_file.sv
// AXI4-Lite register file: RW control words driven to fabric, RO status words sampled on read.
// Independent write (AW/W in any order) and read FSMs, one transaction of each outstanding.
module axi_lite_reg_file #(
    parameter int unsigned       AXI_ADDR_WIDTH = 32,
    parameter int unsigned       N_REGS         = 8,
    parameter logic [N_REGS-1:0] RO_MASK        = '0
) (
    input  logic                  Clk_CI,
    input  logic                  Rst_RI,
    axi_lite_reg_file_if.slave    AxiLite_PS,
    output logic [N_REGS*32-1:0]  Reg_DO,
    input  logic [N_REGS*32-1:0]  RoReg_DI,
    output logic [N_REGS-1:0]     WrPulse_SO
);
    localparam int unsigned IDX_W      = (N_REGS > 1) ? $clog2(N_REGS) : 1;
    localparam logic [1:0]  RespOkay   = 2'b00;
    localparam logic [1:0]  RespSlvErr = 2'b10;
    localparam logic [1:0]  RespDecErr = 2'b11;

    typedef enum logic [1:0] {WIdle, WHaveAw, WHaveW, WResp} wr_state_e;
    typedef enum logic {RIdle, RResp} rd_state_e;

    wr_state_e                 wr_state_q;
    logic                      aw_ready_q, w_ready_q, b_valid_q;
    logic [1:0]                b_resp_q;
    logic [AXI_ADDR_WIDTH-1:0] aw_addr_q;
    logic [31:0]               w_data_q;
    logic [3:0]                w_strb_q;
    logic [N_REGS*32-1:0]      regs_q;
    logic [N_REGS-1:0]         wr_pulse_q;

    rd_state_e                 rd_state_q;
    logic                      ar_ready_q, r_valid_q;
    logic [31:0]               r_data_q;
    logic [1:0]                r_resp_q;

    logic                      aw_hs, w_hs, ar_hs, wr_commit, wr_ro;
    logic [AXI_ADDR_WIDTH-1:0] wr_addr;
    logic [31:0]               wr_data, rd_data;
    logic [3:0]                wr_strb;
    logic [1:0]                wr_resp, rd_resp;
    logic [N_REGS-1:0]         wr_sel;
    logic [IDX_W-1:0]          wr_idx, rd_idx;
    logic                      unused_bits;

    assign aw_hs  = AxiLite_PS.aw_valid & aw_ready_q;
    assign w_hs   = AxiLite_PS.w_valid & w_ready_q;
    assign ar_hs  = AxiLite_PS.ar_valid & ar_ready_q;
    assign wr_idx = wr_addr[2 +: IDX_W];
    assign rd_idx = AxiLite_PS.ar_addr[2 +: IDX_W];
    // Only the index bits decode; the rest are deliberately ignored (window aliases).
    assign unused_bits = ^{wr_addr, AxiLite_PS.ar_addr, RoReg_DI};

    // Pick the commit operands from the bus or from whichever half was latched earlier.
    always_comb begin
        wr_addr   = AxiLite_PS.aw_addr;
        wr_data   = AxiLite_PS.w_data;
        wr_strb   = AxiLite_PS.w_strb;
        wr_commit = 1'b0;
        case (wr_state_q)
            WIdle:   wr_commit = aw_hs & w_hs;
            WHaveAw: begin
                wr_addr   = aw_addr_q;
                wr_commit = w_hs;
            end
            WHaveW:  begin
                wr_data   = w_data_q;
                wr_strb   = w_strb_q;
                wr_commit = aw_hs;
            end
            default: wr_commit = 1'b0;
        endcase
    end

    always_comb begin
        wr_sel  = '0;
        wr_ro   = 1'b0;
        wr_resp = RespDecErr;
        rd_data = '0;
        rd_resp = RespDecErr;
        for (int unsigned i = 0; i < N_REGS; i++) begin
            if (wr_idx == IDX_W'(i)) begin
                wr_sel[i] = 1'b1;
                wr_ro     = RO_MASK[i];
                wr_resp   = RO_MASK[i] ? RespSlvErr : RespOkay;
            end
            if (rd_idx == IDX_W'(i)) begin
                rd_resp = RespOkay;
                rd_data = RO_MASK[i] ? RoReg_DI[32*i +: 32] : regs_q[32*i +: 32];
            end
        end
    end

    always_ff @(posedge Clk_CI) begin
        if (Rst_RI) begin
            regs_q     <= '0;
            wr_pulse_q <= '0;
        end else begin
            wr_pulse_q <= '0;
            if (wr_commit && !wr_ro) begin
                for (int unsigned i = 0; i < N_REGS; i++) begin
                    if (wr_sel[i] && !RO_MASK[i]) begin
                        wr_pulse_q[i] <= 1'b1;
                        for (int unsigned k = 0; k < 4; k++) begin
                            if (wr_strb[k]) regs_q[32*i+8*k +: 8] <= wr_data[8*k +: 8];
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge Clk_CI) begin
        if (Rst_RI) begin
            wr_state_q <= WIdle;
            aw_ready_q <= 1'b0;
            w_ready_q  <= 1'b0;
            b_valid_q  <= 1'b0;
            b_resp_q   <= 2'b00;
            aw_addr_q  <= '0;
            w_data_q   <= '0;
            w_strb_q   <= '0;
        end else begin
            case (wr_state_q)
                WIdle: begin
                    aw_ready_q <= 1'b1;
                    w_ready_q  <= 1'b1;
                    if (wr_commit) begin
                        aw_ready_q <= 1'b0;
                        w_ready_q  <= 1'b0;
                        b_valid_q  <= 1'b1;
                        b_resp_q   <= wr_resp;
                        wr_state_q <= WResp;
                    end else if (aw_hs) begin
                        aw_addr_q  <= AxiLite_PS.aw_addr;
                        aw_ready_q <= 1'b0;
                        wr_state_q <= WHaveAw;
                    end else if (w_hs) begin
                        w_data_q   <= AxiLite_PS.w_data;
                        w_strb_q   <= AxiLite_PS.w_strb;
                        w_ready_q  <= 1'b0;
                        wr_state_q <= WHaveW;
                    end
                end
                WHaveAw, WHaveW: begin
                    if (wr_commit) begin
                        aw_ready_q <= 1'b0;
                        w_ready_q  <= 1'b0;
                        b_valid_q  <= 1'b1;
                        b_resp_q   <= wr_resp;
                        wr_state_q <= WResp;
                    end
                end
                WResp: begin
                    if (AxiLite_PS.b_ready) begin
                        b_valid_q  <= 1'b0;
                        aw_ready_q <= 1'b1;
                        w_ready_q  <= 1'b1;
                        wr_state_q <= WIdle;
                    end
                end
                default: begin
                    aw_ready_q <= 1'b0;
                    w_ready_q  <= 1'b0;
                    b_valid_q  <= 1'b0;
                    wr_state_q <= WIdle;
                end
            endcase
        end
    end

    always_ff @(posedge Clk_CI) begin
        if (Rst_RI) begin
            rd_state_q <= RIdle;
            ar_ready_q <= 1'b0;
            r_valid_q  <= 1'b0;
            r_data_q   <= '0;
            r_resp_q   <= 2'b00;
        end else begin
            case (rd_state_q)
                RIdle: begin
                    ar_ready_q <= 1'b1;
                    if (ar_hs) begin
                        ar_ready_q <= 1'b0;
                        r_valid_q  <= 1'b1;
                        r_data_q   <= rd_data;
                        r_resp_q   <= rd_resp;
                        rd_state_q <= RResp;
                    end
                end
                RResp: begin
                    if (AxiLite_PS.r_ready) begin
                        r_valid_q  <= 1'b0;
                        ar_ready_q <= 1'b1;
                        rd_state_q <= RIdle;
                    end
                end
                default: begin
                    ar_ready_q <= 1'b0;
                    r_valid_q  <= 1'b0;
                    rd_state_q <= RIdle;
                end
            endcase
        end
    end

    assign AxiLite_PS.aw_ready = aw_ready_q;
    assign AxiLite_PS.w_ready  = w_ready_q;
    assign AxiLite_PS.b_valid  = b_valid_q;
    assign AxiLite_PS.b_resp   = b_resp_q;
    assign AxiLite_PS.ar_ready = ar_ready_q;
    assign AxiLite_PS.r_valid  = r_valid_q;
    assign AxiLite_PS.r_data   = r_data_q;
    assign AxiLite_PS.r_resp   = r_resp_q;
    assign Reg_DO              = regs_q;
    assign WrPulse_SO          = wr_pulse_q;
endmodule

// File: tb/tb_axi_lite_reg_file.sv
// Directed bench for axi_lite_reg_file: 6 registers, word 5 read-only; B/R responses
// are checked against a scoreboard filled when the request is driven.
module tb_axi_lite_reg_file;
    localparam int NR = 6;
    typedef logic [191:0] cv_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    axi_lite_reg_file_if #(.AXI_ADDR_WIDTH(32)) bus ();
    logic [NR*32-1:0] reg_do, ro_di;
    logic [NR-1:0]    pulse;

    axi_lite_reg_file #(
        .AXI_ADDR_WIDTH(32),
        .N_REGS        (NR),
        .RO_MASK       (6'b100000)
    ) dut (
        .Clk_CI    (clk),
        .Rst_RI    (rst),
        .AxiLite_PS(bus),
        .Reg_DO    (reg_do),
        .RoReg_DI  (ro_di),
        .WrPulse_SO(pulse)
    );

    int          total = 0;
    int          bad   = 0;
    logic [1:0]  exp_b[$];
    logic [33:0] exp_r[$];
    logic [31:0] model[NR];
    logic [NR-1:0] ep;

    task automatic check(input string tag, input cv_t obs, input cv_t exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic cv_t model_vec();
        cv_t v = '0;
        for (int i = 0; i < NR; i++) v[32*i +: 32] = model[i];
        return v;
    endfunction

    // Queues the expected B response, updates the model, returns the expected pulse mask.
    function automatic logic [NR-1:0] wr_expect(input logic [31:0] a, input logic [31:0] d,
                                                input logic [3:0] s);
        int idx = int'(a[4:2]);
        logic [NR-1:0] p = '0;
        exp_b.push_back(idx >= NR ? 2'b11 : (idx == 5 ? 2'b10 : 2'b00));
        if (idx < 5) begin
            for (int k = 0; k < 4; k++) if (s[k]) model[idx][8*k +: 8] = d[8*k +: 8];
            p[idx] = 1'b1;
        end
        return p;
    endfunction

    function automatic logic [33:0] rd_expect(input logic [31:0] a);
        int idx = int'(a[4:2]);
        if (idx >= NR) return {2'b11, 32'h0};
        if (idx == 5) return {2'b00, ro_di[160 +: 32]};
        return {2'b00, model[idx]};
    endfunction

    task automatic hs(input bit do_aw, input bit do_w, input logic [31:0] addr,
                      input logic [31:0] data, input logic [3:0] strb);
        bit aw_p, w_p, a, w;
        int n;
        aw_p = do_aw; w_p = do_w; n = 0;
        bus.aw_addr = addr; bus.w_data = data; bus.w_strb = strb;
        bus.aw_valid = do_aw; bus.w_valid = do_w;
        while ((aw_p || w_p) && n < 20) begin
            a = aw_p && bus.aw_ready;
            w = w_p && bus.w_ready;
            @(posedge clk); #1; n++;
            if (a) begin aw_p = 1'b0; bus.aw_valid = 1'b0; end
            if (w) begin w_p = 1'b0; bus.w_valid = 1'b0; end
        end
        check("aw_w_handshake_timeout", cv_t'({aw_p, w_p}), cv_t'(0));
    endtask

    task automatic send_ar(input logic [31:0] addr);
        bit p, a;
        int n;
        p = 1'b1; n = 0;
        exp_r.push_back(rd_expect(addr));
        bus.ar_addr = addr; bus.ar_valid = 1'b1;
        while (p && n < 20) begin
            a = bus.ar_ready;
            @(posedge clk); #1; n++;
            if (a) begin p = 1'b0; bus.ar_valid = 1'b0; end
        end
        check("ar_handshake_timeout", cv_t'(p), cv_t'(0));
    endtask

    task automatic get_b();
        int n = 0;
        logic [1:0] e;
        while (!bus.b_valid && n < 20) begin @(posedge clk); #1; n++; end
        check("b_valid_timeout", cv_t'(bus.b_valid), cv_t'(1));
        e = (exp_b.size() > 0) ? exp_b.pop_front() : 2'bxx;
        check("b_resp", cv_t'(bus.b_resp), cv_t'(e));
        bus.b_ready = 1'b1;
        @(posedge clk); #1;
        bus.b_ready = 1'b0;
    endtask

    task automatic get_r();
        int n = 0;
        logic [33:0] e;
        while (!bus.r_valid && n < 20) begin @(posedge clk); #1; n++; end
        check("r_valid_timeout", cv_t'(bus.r_valid), cv_t'(1));
        e = (exp_r.size() > 0) ? exp_r.pop_front() : 34'bx;
        check("r_resp_data", cv_t'({bus.r_resp, bus.r_data}), cv_t'(e));
        bus.r_ready = 1'b1;
        @(posedge clk); #1;
        bus.r_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        ro_di = '0;
        bus.aw_valid = 1'b0; bus.aw_addr = '0; bus.w_valid = 1'b0; bus.w_data = '0;
        bus.w_strb = '0; bus.b_ready = 1'b0; bus.ar_valid = 1'b0; bus.ar_addr = '0;
        bus.r_ready = 1'b0;
        for (int i = 0; i < NR; i++) model[i] = '0;

        // Reset state and ready release.
        repeat (3) @(posedge clk);
        #1;
        check("reset_ctl", cv_t'({bus.aw_ready, bus.w_ready, bus.ar_ready, bus.b_valid,
                                  bus.r_valid, bus.b_resp, bus.r_resp}), cv_t'(0));
        check("reset_rdata", cv_t'(bus.r_data), cv_t'(0));
        check("reset_regs", cv_t'(reg_do), cv_t'(0));
        check("reset_pulse", cv_t'(pulse), cv_t'(0));
        rst = 1'b0;
        @(posedge clk); #1;
        check("ready_rise", cv_t'({bus.aw_ready, bus.w_ready, bus.ar_ready}), cv_t'(3'b111));

        // Simultaneous AW+W.
        ep = wr_expect(32'h04, 32'hDEADBEEF, 4'hF);
        hs(1'b1, 1'b1, 32'h04, 32'hDEADBEEF, 4'hF);
        check("wr1_pulse", cv_t'(pulse), cv_t'(6'h02));
        check("wr1_b_latency", cv_t'(bus.b_valid), cv_t'(1));
        check("wr1_reg", cv_t'(reg_do[63:32]), cv_t'(32'hDEADBEEF));
        get_b();
        check("wr1_pulse_one_cycle", cv_t'(pulse), cv_t'(0));

        // W three cycles ahead of AW.
        ep = wr_expect(32'h08, 32'h11223344, 4'b0101);
        hs(1'b0, 1'b1, 32'h0, 32'h11223344, 4'b0101);
        repeat (3) @(posedge clk);
        #1;
        check("have_w_ready", cv_t'({bus.aw_ready, bus.w_ready, bus.b_valid}), cv_t'(3'b100));
        hs(1'b1, 1'b0, 32'h08, 32'h0, 4'h0);
        check("wfirst_pulse", cv_t'(pulse), cv_t'(ep));
        check("wfirst_reg", cv_t'(reg_do[95:64]), cv_t'(32'h00220044));
        get_b();

        // AW ahead of W.
        ep = wr_expect(32'h0C, 32'hA5A55A5A, 4'hF);
        hs(1'b1, 1'b0, 32'h0C, 32'h0, 4'h0);
        check("have_aw_ready", cv_t'({bus.aw_ready, bus.w_ready, bus.b_valid}), cv_t'(3'b010));
        @(posedge clk); #1;
        hs(1'b0, 1'b1, 32'h0, 32'hA5A55A5A, 4'hF);
        check("awfirst_pulse", cv_t'(pulse), cv_t'(6'h08));
        get_b();
        check("regs_after_split", cv_t'(reg_do), model_vec());

        // Error responses: RO word and out-of-range index.
        ep = wr_expect(32'h14, 32'hFFFFFFFF, 4'hF);
        hs(1'b1, 1'b1, 32'h14, 32'hFFFFFFFF, 4'hF);
        check("slverr_no_pulse", cv_t'(pulse), cv_t'(ep));
        get_b();
        ep = wr_expect(32'h18, 32'hFFFFFFFF, 4'hF);
        hs(1'b1, 1'b1, 32'h18, 32'hFFFFFFFF, 4'hF);
        check("decerr_no_pulse", cv_t'(pulse), cv_t'(0));
        get_b();
        check("regs_after_err", cv_t'(reg_do), model_vec());
        send_ar(32'h18);
        get_r();
        send_ar(32'h1C);
        get_r();
        ro_di[160 +: 32] = 32'hCAFEF00D;
        send_ar(32'h14);
        ro_di[160 +: 32] = 32'h0;
        get_r();
        send_ar(32'h26);
        get_r();

        // Backpressure on both response channels.
        ep = wr_expect(32'h10, 32'h0BADCAFE, 4'b1100);
        hs(1'b1, 1'b1, 32'h10, 32'h0BADCAFE, 4'b1100);
        send_ar(32'h04);
        for (int c = 0; c < 10; c++) begin
            check("backpressure_hold",
                  cv_t'({bus.b_valid, bus.r_valid, bus.aw_ready, bus.w_ready, bus.ar_ready,
                         bus.b_resp, bus.r_resp, bus.r_data}),
                  cv_t'({5'b11000, 2'b00, 2'b00, 32'hDEADBEEF}));
            @(posedge clk); #1;
        end
        get_b();
        get_r();
        check("regs_after_bp", cv_t'(reg_do[159:128]), cv_t'(32'h0BAD0000));

        // Same-cycle read and write of register 0.
        ep = wr_expect(32'h00, 32'h1, 4'hF);
        hs(1'b1, 1'b1, 32'h00, 32'h1, 4'hF);
        get_b();
        exp_r.push_back({2'b00, 32'h1});
        ep = wr_expect(32'h00, 32'h5, 4'hF);
        bus.ar_addr = 32'h00; bus.ar_valid = 1'b1;
        hs(1'b1, 1'b1, 32'h00, 32'h5, 4'hF);
        bus.ar_valid = 1'b0;
        check("collision_both_valid", cv_t'({bus.b_valid, bus.r_valid}), cv_t'(2'b11));
        get_r();
        get_b();
        send_ar(32'h00);
        get_r();

        // Reset in W_HAVE_AW and R_RESP drops both transactions.
        hs(1'b1, 1'b0, 32'h04, 32'h0, 4'h0);
        send_ar(32'h08);
        exp_r.delete();
        rst = 1'b1;
        @(posedge clk); #1;
        check("midreset_ctl", cv_t'({bus.aw_ready, bus.w_ready, bus.ar_ready, bus.b_valid,
                                     bus.r_valid, bus.b_resp, bus.r_resp, bus.r_data}),
              cv_t'(0));
        check("midreset_regs", cv_t'({reg_do, pulse}), cv_t'(0));
        for (int i = 0; i < NR; i++) model[i] = '0;
        rst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            check("no_stale_resp", cv_t'({bus.b_valid, bus.r_valid}), cv_t'(0));
        end
        send_ar(32'h04);
        get_r();
        send_ar(32'h08);
        get_r();
        check("scoreboard_drained", cv_t'(exp_b.size() + exp_r.size()), cv_t'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
